// File: rtl/serial_tx_pkg.sv
// Shared definitions for the single-wire serial link (transmitter, receiver, benches).
// State encodings, line levels, default frame parameters and a parity helper.
package serial_tx_pkg;

    // Fixed 3-bit encoding shared with the receiver and the benches.
    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StStart = 3'd1,
        StData  = 3'd2,
        StPar   = 3'd3,
        StStop  = 3'd4
    } tx_state_e;

    // Line levels: idle/stop is mark (1), start is space (0).
    localparam logic IDLE_LVL  = 1'b1;
    localparam logic START_LVL = 1'b0;

    localparam int unsigned DEFAULT_WIDTH        = 8;
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 4;

    // Baud counter width; covers CLKS_PER_BIT up to 255.
    localparam int unsigned BAUD_CNT_W = 8;

    // Even parity over the data bits: XOR of all bits (unused bits are zero).
    function automatic logic even_parity(input logic [15:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/serial_baud_tick.sv
// Modulo-CLKS_PER_BIT counter with synchronous clear. Emits a one-cycle tick in the
// last count of each bit period, i.e. on the cycle whose edge wraps the counter.
module serial_baud_tick
    import serial_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam logic [BAUD_CNT_W-1:0] LAST = BAUD_CNT_W'(CLKS_PER_BIT - 1);

    logic [BAUD_CNT_W-1:0] cnt_q, cnt_d;

    // With CLKS_PER_BIT=1 LAST is 0, so tick is asserted every cycle.
    assign tick = (cnt_q == LAST);

    // Next count: wrap on tick, hold at zero while cleared.
    always_comb begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        if (clr) begin
            cnt_d = '0;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_tx.sv
// Framed parallel-in/serial-out transmitter: start(0), WIDTH data bits LSB-first,
// optional even parity bit, stop(1); each bit held CLKS_PER_BIT clocks.
// Optional feature macro: SERIAL_TX_PARITY_EN inserts the parity bit.
// All outputs are registered; acceptance drives the start bit on the same edge.
module serial_tx
    import serial_tx_pkg::*;
#(
    parameter int unsigned WIDTH        = DEFAULT_WIDTH,
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic             C,
    input  logic             R,
    input  logic [WIDTH-1:0] D_IN,
    input  logic             LOAD,
    output logic             READY,
    output logic             TX,
    output logic             BUSY,
    output logic             DONE
);

    localparam int unsigned    CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    tx_state_e        state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
    logic             tx_q, tx_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tick;
    logic             accept;
    logic             baud_clr;

    assign accept = LOAD && ready_q;

    // Counter sits at zero while idle so the start bit gets a full period from acceptance.
    assign baud_clr = (state_q == StIdle);

    serial_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk (C),
        .rst (R),
        .clr (baud_clr),
        .tick(tick)
    );

`ifdef SERIAL_TX_PARITY_EN
    logic parity_q;

    // Parity is latched with the word so it does not depend on the shifting register.
    always_ff @(posedge C) begin
        if (R) begin
            parity_q <= 1'b0;
        end else if (accept) begin
            parity_q <= even_parity(16'(D_IN));
        end
    end
`endif

    // State, datapath and registered outputs.
    always_ff @(posedge C) begin
        if (R) begin
            state_q  <= StIdle;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            tx_q     <= IDLE_LVL;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            tx_q     <= tx_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state: each non-idle state advances on a baud tick.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StStart;
            StStart: if (tick) state_d = StData;
            StData: begin
                if (tick && (bitcnt_q == LAST_BIT)) begin
`ifdef SERIAL_TX_PARITY_EN
                    state_d = StPar;
`else
                    state_d = StStop;
`endif
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            StPar:   if (tick) state_d = StStop;
`endif
            StStop:  if (tick) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Shift register and bit counter: load on acceptance, shift on each data-bit boundary.
    always_comb begin
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        if (accept) begin
            shreg_d  = D_IN;
            bitcnt_d = '0;
        end else if ((state_q == StData) && tick) begin
            shreg_d  = shreg_q >> 1;
            bitcnt_d = (bitcnt_q == LAST_BIT) ? '0 : bitcnt_q + 1'b1;
        end
    end

    // Output decode from the upcoming state so the registered outputs line up with it.
    // READY only returns in the DONE cycle, so a back-to-back word starts one cycle later.
    always_comb begin
        tx_d    = IDLE_LVL;
        ready_d = (state_d == StIdle);
        busy_d  = (state_d != StIdle);
        done_d  = (state_q == StStop) && tick;
        unique case (state_d)
            StIdle:  tx_d = IDLE_LVL;
            StStart: tx_d = START_LVL;
            StData:  tx_d = shreg_d[0];
`ifdef SERIAL_TX_PARITY_EN
            StPar:   tx_d = parity_q;
`endif
            StStop:  tx_d = IDLE_LVL;
            default: tx_d = IDLE_LVL;
        endcase
    end

    assign READY = ready_q;
    assign TX    = tx_q;
    assign BUSY  = busy_q;
    assign DONE  = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx (WIDTH=8, CLKS_PER_BIT=4): directed frames plus random traffic,
// compared cycle by cycle against a frame-level reference model.
module tb_serial_tx;

    localparam int W = 8;
    localparam int N = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int NBITS = W + 3;
`else
    localparam int NBITS = W + 2;
`endif
    localparam int FRAME_LEN = NBITS * N;

    logic         C = 1'b0;
    logic         R;
    logic [W-1:0] D_IN;
    logic         LOAD;
    logic         READY, TX, BUSY, DONE;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a frame is in flight for FRAME_LEN cycles after acceptance.
    bit           m_active = 1'b0;
    bit           m_done   = 1'b0;
    int           m_age    = 0;
    logic [W-1:0] m_word   = '0;

    serial_tx #(
        .WIDTH(W),
        .CLKS_PER_BIT(N)
    ) dut (
        .C    (C),
        .R    (R),
        .D_IN (D_IN),
        .LOAD (LOAD),
        .READY(READY),
        .TX   (TX),
        .BUSY (BUSY),
        .DONE (DONE)
    );

    always #5 C = ~C;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Line level of bit i of the current frame: start, data LSB-first, [parity], stop.
    function automatic logic frame_bit(input int i);
        if (i == 0) return 1'b0;
        if (i <= W) return m_word[i-1];
`ifdef SERIAL_TX_PARITY_EN
        if (i == W + 1) return ^m_word;
`endif
        return 1'b1;
    endfunction

    // Advance the model by one rising edge using the inputs present at that edge.
    task automatic model_step();
        m_done = 1'b0;
        if (R) begin
            m_active = 1'b0;
        end else if (m_active) begin
            m_age++;
            if (m_age == FRAME_LEN) begin
                m_active = 1'b0;
                m_done   = 1'b1;
            end
        end else if (LOAD) begin
            m_active = 1'b1;
            m_word   = D_IN;
            m_age    = 0;
        end
    endtask

    // Drive inputs away from the edge, clock once, then compare on the falling edge.
    task automatic step(input logic r, input logic ld, input logic [W-1:0] d);
        logic exp_tx;
        R    = r;
        LOAD = ld;
        D_IN = d;
        @(posedge C);
        model_step();
        @(negedge C);
        exp_tx = m_active ? frame_bit(m_age / N) : 1'b1;
        check("tx",    TX,    exp_tx);
        check("ready", READY, !m_active);
        check("busy",  BUSY,  m_active);
        check("done",  DONE,  m_done);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, W'($urandom));
    endtask

    initial begin
        R    = 1'b1;
        LOAD = 1'b1;
        D_IN = 8'h5A;
        @(negedge C);

        // Reset held two edges with LOAD high: nothing may start.
        step(1'b1, 1'b1, 8'h5A);
        step(1'b1, 1'b1, 8'h5A);
        idle(3);

        // Single frame.
        step(1'b0, 1'b1, 8'hA5);
        idle(FRAME_LEN + 5);

        // Back-to-back: LOAD held high through the DONE cycle.
        step(1'b0, 1'b1, 8'h3C);
        for (int i = 0; i < FRAME_LEN + 2; i++) step(1'b0, 1'b1, 8'hFF);
        idle(FRAME_LEN + 5);

        // Load while busy is ignored.
        step(1'b0, 1'b1, 8'hA5);
        idle(10);
        step(1'b0, 1'b1, 8'h00);
        idle(FRAME_LEN + 5);

        // Reset during data bit 3, then a fresh frame.
        step(1'b0, 1'b1, 8'h81);
        idle(16);
        step(1'b1, 1'b0, 8'h00);
        idle(3);
        step(1'b0, 1'b1, 8'h01);
        idle(FRAME_LEN + 5);

        // Parity-sensitive words.
        step(1'b0, 1'b1, 8'h07);
        idle(FRAME_LEN + 3);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0, W'($urandom));
        end
        idle(FRAME_LEN + 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
